pipelined_addsub: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor; successor to the 32-bit combinational full adder.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_seg_stage.sv | 76 +++++++
 rtl/pipelined_addsub.sv | 101 ++++++++++
 tb/tb_pipelined_addsub.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and configuration helpers for the pipelined adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Bits handled by each carry-chain segment.
  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_seg_stage.sv
// One carry-chain segment: a SEG-bit add on its slice plus the stage register and advance control.
module addsub_seg_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8,
  parameter int unsigned IDX   = 0,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_next,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  input  logic             in_amsb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  output logic [WIDTH-1:0] out_b,
  output logic             out_carry,
  output logic             out_amsb,
  output logic [TAG_W-1:0] out_tag
);
  import addsub_pkg::*;

  localparam int unsigned Lo = IDX * SEG;

  logic             valid_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             amsb_q;
  logic [TAG_W-1:0] tag_q;

  logic             adv;
  logic [SEG:0]     seg_sum;
  logic [WIDTH-1:0] word_d;

  // Lower bits of the word are finished sum, upper bits are still operand A.
  always_comb begin
    seg_sum = {1'b0, in_word[Lo +: SEG]} + {1'b0, in_b[Lo +: SEG]} + {{SEG{1'b0}}, in_carry};
    word_d  = in_word;
    word_d[Lo +: SEG] = seg_sum[SEG-1:0];
  end

  // An empty stage always takes its predecessor's contents, so bubbles collapse.
  assign adv = !valid_q | adv_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      amsb_q  <= 1'b0;
      tag_q   <= '0;
    end else if (adv) begin
      valid_q <= in_valid;
      if (in_valid) begin
        word_q  <= word_d;
        b_q     <= in_b;
        carry_q <= seg_sum[SEG];
        amsb_q  <= in_amsb;
        tag_q   <= in_tag;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_b     = b_q;
  assign out_carry = carry_q;
  assign out_amsb  = amsb_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready streaming, tag sideband and
// signed-overflow flag; the carry chain is cut into STAGES registered segments.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             global_resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SEG = seg_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : gen_cfg_check
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  // Index k is the input of stage k; index STAGES is the output of the last stage.
  logic [STAGES:0]              valid_c;
  logic [STAGES:0]              carry_c;
  logic [STAGES:0]              amsb_c;
  logic [STAGES:0][WIDTH-1:0]   word_c;
  logic [STAGES:0][WIDTH-1:0]   b_c;
  logic [STAGES:0][TAG_W-1:0]   tag_c;
  logic [STAGES-1:0]            adv_next;
  logic                         is_sub;

  // Subtraction is A + ~B + ~cin, so the conditioning happens once, at accept.
  assign is_sub     = (in_op == OP_SUB);
  assign valid_c[0] = in_valid;
  assign word_c[0]  = in_a;
  assign b_c[0]     = is_sub ? ~in_b : in_b;
  assign carry_c[0] = is_sub ? ~in_cin : in_cin;
  assign amsb_c[0]  = in_a[WIDTH-1];
  assign tag_c[0]   = in_tag;

  // Advance chain evaluated from the registered valids, last stage first.
  always_comb begin
    logic adv;
    adv      = out_ready;
    adv_next = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv_next[k] = adv;
      adv         = !valid_c[k+1] | adv;
    end
    in_ready = adv;
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    addsub_seg_stage #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .IDX   (k),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (global_resetn),
      .adv_next  (adv_next[k]),
      .in_valid  (valid_c[k]),
      .in_word   (word_c[k]),
      .in_b      (b_c[k]),
      .in_carry  (carry_c[k]),
      .in_amsb   (amsb_c[k]),
      .in_tag    (tag_c[k]),
      .out_valid (valid_c[k+1]),
      .out_word  (word_c[k+1]),
      .out_b     (b_c[k+1]),
      .out_carry (carry_c[k+1]),
      .out_amsb  (amsb_c[k+1]),
      .out_tag   (tag_c[k+1])
    );
  end

  assign out_valid = valid_c[STAGES];
  assign out_sum   = word_c[STAGES];
  assign out_cout  = carry_c[STAGES];
  assign out_tag   = tag_c[STAGES];
  // Overflow when both addends share a sign that the result does not.
  assign out_ovf   = (amsb_c[STAGES] == b_c[STAGES][WIDTH-1]) &
                     (word_c[STAGES][WIDTH-1] != amsb_c[STAGES]);

  // Only the MSB of the conditioned B is needed once the chain is complete.
  logic unused_b;
  assign unused_b = ^b_c[STAGES];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corner cases, random streaming,
// random backpressure and reset mid-stream, all checked against an arithmetic model.
module tb_pipelined_addsub;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 4;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          global_resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          in_op = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  pipelined_addsub #(
    .WIDTH  (W),
    .STAGES (S),
    .TAG_W  (TW)
  ) dut (
    .clk           (clk),
    .global_resetn (global_resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_cin        (in_cin),
    .in_op         (in_op),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_cout      (out_cout),
    .out_ovf       (out_ovf),
    .out_tag       (out_tag)
  );

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cycle = 0;
  bit   lat_check = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: A+B+cin or A-B-cin, flags from the exact results.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic op, input logic [TW-1:0] tag);
    exp_t e;
    longint unsigned ua, ub, ures;
    longint sa, sb, sres, smax, smin;
    ua   = 64'(a);
    ub   = 64'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (!op) begin
      ures   = ua + ub + 64'(cin);
      sres   = sa + sb + longint'(cin);
      e.cout = ures[W];
    end else begin
      ures   = ua - ub - 64'(cin);
      sres   = sa - sb - longint'(cin);
      e.cout = (ua >= ub + 64'(cin));
    end
    e.sum = ures[W-1:0];
    e.ovf = (sres > smax) || (sres < smin);
    e.tag = tag;
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Monitor: at the negedge the values are those the next rising edge will act on.
  logic              prev_stall = 1'b0;
  logic [W+TW+1:0]   prev_out = '0;

  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (!global_resetn) begin
      prev_stall = 1'b0;
    end else begin
      check_eq("in_ready_rule", 64'(in_ready), 64'(!(exp_q.size() == S && !out_ready)));
      if (prev_stall)
        check_eq("stall_hold", {out_valid, out_cout, out_ovf, out_tag, out_sum}, {1'b1, prev_out});
      prev_out   = {out_cout, out_ovf, out_tag, out_sum};
      prev_stall = out_valid & !out_ready;
      if (out_valid && out_ready) begin
        check_eq("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("sum", out_sum, e.sum);
          check_eq("cout", out_cout, e.cout);
          check_eq("ovf", out_ovf, e.ovf);
          check_eq("tag", out_tag, e.tag);
          if (e.lat) check_eq("latency", 64'(cycle - e.acc), 64'(S));
        end
      end
      if (in_valid && in_ready) begin
        e     = model(in_a, in_b, in_cin, in_op, in_tag);
        e.acc = cycle;
        e.lat = lat_check;
        exp_q.push_back(e);
      end
    end
  end

  task automatic run_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic op, input logic [TW-1:0] tag,
                              input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    @(posedge clk); #1;
    lat_check = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_op     = op;
    in_tag    = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check_eq({name, "_lat"}, 64'(n), 64'(S));
    check_eq({name, "_sum"}, out_sum, es);
    check_eq({name, "_cout"}, out_cout, ec);
    check_eq({name, "_ovf"}, out_ovf, eo);
    check_eq({name, "_tag"}, out_tag, tag);
  endtask

  task automatic drive_random(input int unsigned i);
    in_a = $urandom;
    case ($urandom_range(0, 3))
      0: in_b = $urandom;
      1: begin in_a = 32'h7FFF_FFFF; in_b = $urandom; end
      2: in_b = ~in_a;
      default: in_b = in_a;
    endcase
    in_cin = 1'($urandom);
    in_op  = 1'($urandom);
    in_tag = TW'(i);
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_sum", out_sum, 0);
    check_eq("rst_cout", out_cout, 0);
    check_eq("rst_ovf", out_ovf, 0);
    check_eq("rst_tag", out_tag, 0);
    @(posedge clk); #3;
    global_resetn = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", in_ready, 1);

    run_directed("add_alt", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 4'h1, 32'hFFFF_FFFF, 0, 0);
    run_directed("add_rip", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 4'h2, 32'h0000_0000, 1, 0);
    run_directed("sub_0m1", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h3, 32'hFFFF_FFFF, 0, 0);
    run_directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h4, 32'h8000_0000, 0, 1);
    run_directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h5, 32'h7FFF_FFFF, 1, 1);
    run_directed("sub_brw", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 4'hA, 32'h0000_0001, 1, 0);
    drain();

    // Full-rate streaming with continuous acceptance.
    @(posedge clk); #1;
    lat_check = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1;
      drive_random(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Random valid and backpressure.
    lat_check = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = 1'(($urandom_range(0, 1)));
      drive_random(i);
      @(posedge clk); #1;
    end
    drain();

    // Reset with three beats in flight and the output stalled.
    lat_check = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive_random(i + 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_valid", out_valid, 1);
    global_resetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_sum", out_sum, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    global_resetn = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    run_directed("post_rst", 32'h1234_5678, 32'h0000_0008, 1'b1, 1'b1, 4'h7, 32'h1234_566F, 1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
